// File: rtl/tile_color_mapper_if.sv
// Pixel stream between the VGA controller, the colour mapper and the DAC pins.
// The master drives coordinates and receives the registered colour.
interface tile_color_mapper_if;
  logic       draw_valid;
  logic       blank;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_valid;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (output draw_valid, blank, DrawX, DrawY,
                  input  pix_valid, VGA_R, VGA_G, VGA_B);
  modport slave  (input  draw_valid, blank, DrawX, DrawY,
                  output pix_valid, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/tile_color_mapper.sv
// Tile-based background colour mapper: region decode, tile-map lookup, sprite ROM
// address generation, palette lookup. Fixed 4-edge latency, one pixel per cycle.
module tile_color_mapper #(
  parameter int          TILE_W   = 30,
  parameter int          TILE_H   = 30,
  parameter int          MAP_COLS = 16,
  parameter int          MAP_ROWS = 16,
  parameter int          X_OFFSET = 80,
  parameter int          STATE_W  = 4,
  parameter int          CIDX_W   = 4,
  parameter int          ROM_AW   = 13,
  parameter logic [23:0] BORDER_L = 24'hA915F0,
  parameter logic [23:0] BORDER_R = 24'h72C82F,
  localparam int         MAP_N    = MAP_COLS * MAP_ROWS,
  localparam int         MAW      = (MAP_N > 1) ? $clog2(MAP_N) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  tile_color_mapper_if.slave  vga,
  input  logic                map_we,
  input  logic [MAW-1:0]      map_addr,
  input  logic [STATE_W-1:0]  map_data,
  input  logic                pal_we,
  input  logic [CIDX_W-1:0]   pal_addr,
  input  logic [23:0]         pal_data,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [CIDX_W-1:0]   rom_data
);
  localparam int MAP_W  = MAP_COLS * TILE_W;
  localparam int MAP_H  = MAP_ROWS * TILE_H;
  localparam int OXW    = $clog2(TILE_W + 1);
  localparam int OYW    = $clog2(TILE_H + 1);
  localparam int PAL_N  = 1 << CIDX_W;
  localparam int STAGES = 3;

  typedef enum logic [1:0] {RG_MAP, RG_LEFT, RG_RIGHT} region_t;

  function automatic logic [23:0] pal_default(input int i);
    case (i)
      0:  return 24'hA915F0;  1:  return 24'h72C82F;
      2:  return 24'h3CABDD;  3:  return 24'h93CF81;
      4:  return 24'h98E7D8;  5:  return 24'h37E2D5;
      6:  return 24'h22BBE6;  7:  return 24'hFCC656;
      8:  return 24'hA87C07;  9:  return 24'hCB8C1A;
      10: return 24'hE78924;  11: return 24'hF2AB45;
      12: return 24'hA0611F;  13: return 24'h0964C8;
      14: return 24'hFBFEF2;  15: return 24'h39403A;
      default: return 24'h000000;
    endcase
  endfunction

  logic [STATE_W-1:0] tmap [MAP_N];
  logic [23:0]        pal  [PAL_N];

  // stage-0 decode; offsets and tile index are only meaningful inside the map
  region_t        rg0;
  logic [MAW-1:0] idx0;
  logic [OXW-1:0] ox0;
  logic [OYW-1:0] oy0;
  int             x, y, dx;

  always_comb begin
    x    = int'(vga.DrawX);
    y    = int'(vga.DrawY);
    dx   = 0;
    rg0  = RG_MAP;
    idx0 = '0;
    ox0  = '0;
    oy0  = '0;
    if (x < X_OFFSET || y >= MAP_H) rg0 = RG_LEFT;
    else if (x >= X_OFFSET + MAP_W) rg0 = RG_RIGHT;
    else begin
      dx   = x - X_OFFSET;
      idx0 = MAW'(dx / TILE_W + (y / TILE_H) * MAP_COLS);
      ox0  = OXW'(dx % TILE_W);
      oy0  = OYW'(y % TILE_H);
    end
  end

  logic [STAGES:0]      vld_pipe, blk_pipe;
  logic [STAGES:0][1:0] rg_pipe;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_pipe <= '0;
      blk_pipe <= '0;
      rg_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], vga.draw_valid};
      blk_pipe <= {blk_pipe[STAGES-1:0], vga.blank};
      rg_pipe  <= {rg_pipe[STAGES-1:0], 2'(rg0)};
    end
  end

  // map read at the sampling edge sees the pre-write contents
  logic [STATE_W-1:0] map_q;
  logic [OXW-1:0]     ox1;
  logic [OYW-1:0]     oy1;
  logic [ROM_AW-1:0]  base2, lin2;

  always_ff @(posedge Clk) begin
    map_q <= tmap[idx0];
    ox1   <= ox0;
    oy1   <= oy0;
    base2 <= ROM_AW'(int'(map_q) * (TILE_W * TILE_H));
    lin2  <= ROM_AW'(int'(oy1) * TILE_W + int'(ox1));
    if (map_we) tmap[map_addr] <= map_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rom_addr <= '0;
    else       rom_addr <= base2 + lin2;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= pal_default(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  logic [23:0] rgb_q;
  logic        pv_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      pv_q <= vld_pipe[STAGES];
      if (!vld_pipe[STAGES] || blk_pipe[STAGES]) rgb_q <= '0;
      else if (rg_pipe[STAGES] == RG_LEFT)       rgb_q <= BORDER_L;
      else if (rg_pipe[STAGES] == RG_RIGHT)      rgb_q <= BORDER_R;
      else                                       rgb_q <= pal[rom_data];
    end
  end

  assign vga.pix_valid = pv_q;
  assign vga.VGA_R     = rgb_q[23:16];
  assign vga.VGA_G     = rgb_q[15:8];
  assign vga.VGA_B     = rgb_q[7:0];
endmodule

// File: tb/tb_tile_color_mapper.sv
// Bench for tile_color_mapper: directed scenarios plus randomized streams checked
// against a pixel-queue reference model with a registered sprite ROM model.
module tb_tile_color_mapper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_color_mapper_if vga();
  logic        map_we, pal_we;
  logic [7:0]  map_addr;
  logic [3:0]  map_data, pal_addr, rom_data;
  logic [23:0] pal_data;
  logic [12:0] rom_addr;

  tile_color_mapper dut (
    .Clk(clk), .Reset(rst), .vga(vga),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  logic [3:0] rom_mem [8192];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  localparam logic [23:0] PAL_DEF [16] = '{
    24'hA915F0, 24'h72C82F, 24'h3CABDD, 24'h93CF81, 24'h98E7D8, 24'h37E2D5,
    24'h22BBE6, 24'hFCC656, 24'hA87C07, 24'hCB8C1A, 24'hE78924, 24'hF2AB45,
    24'hA0611F, 24'h0964C8, 24'hFBFEF2, 24'h39403A};

  int compared = 0;
  int mismatched = 0;
  logic [23:0] dut_rgb;
  assign dut_rgb = {vga.VGA_R, vga.VGA_G, vga.VGA_B};

  // reference model: each sampled pixel becomes a record due four edges later;
  // the map is read when sampled, the palette when the record falls due
  typedef struct { int due; bit v; bit b; int rg; int cidx; } px_t;
  px_t         q[$];
  px_t         np, op;
  int          cyc = 0;
  int          mmap [256];
  logic [23:0] mpal [16];
  bit          exp_pv;
  logic [23:0] exp_rgb;
  int          mx, my, st;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        exp_pv = 0;
        exp_rgb = '0;
        for (int i = 0; i < 16; i++) mpal[i] = PAL_DEF[i];
      end else begin
        cyc++;
        exp_pv = 0;
        exp_rgb = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          op = q.pop_front();
          exp_pv = op.v;
          if (op.v && !op.b)
            exp_rgb = (op.rg == 1) ? 24'hA915F0 : (op.rg == 2) ? 24'h72C82F : mpal[op.cidx];
        end
        mx = int'(vga.DrawX);
        my = int'(vga.DrawY);
        np.due = cyc + 4;
        np.v = vga.draw_valid;
        np.b = vga.blank;
        np.cidx = 0;
        if (mx < 80 || my >= 480) np.rg = 1;
        else if (mx >= 560) np.rg = 2;
        else begin
          np.rg = 0;
          st = mmap[(mx - 80) / 30 + (my / 30) * 16];
          np.cidx = int'(rom_mem[(st * 900 + (my % 30) * 30 + (mx - 80) % 30) % 8192]);
        end
        q.push_back(np);
        if (map_we) mmap[map_addr] = int'(map_data);
        if (pal_we) mpal[pal_addr] = pal_data;
      end
    end
  end

  task drive(input bit v, input bit b, input int x, input int y);
    vga.draw_valid = v;
    vga.blank = b;
    vga.DrawX = 10'(x);
    vga.DrawY = 10'(y);
  endtask

  task test_reset;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, $urandom_range(0, 79), 5);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (vga.pix_valid !== 1'b0 || dut_rgb !== 24'h0 || rom_addr !== 13'd0) begin
      mismatched++;
      $display("FAIL reset_async: pv=%b rgb=%h rom_addr=%0d, want 0/000000/0", vga.pix_valid, dut_rgb, rom_addr);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (vga.pix_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_flush: cycle %0d pv=%b, want 0", i, vga.pix_valid);
      end
    end
    map_we = 1; map_addr = 8'd16; map_data = 4'd0;
    rom_mem[320] = 4'd1;
    @(negedge clk);
    map_we = 0;
    drive(1, 0, 100, 40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      if (i == 3) begin
        compared++;
        if (vga.pix_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_first_early: pv=%b at E0+3, want 0", vga.pix_valid);
        end
      end
      if (i == 4) begin
        compared++;
        if (vga.pix_valid !== 1'b1 || dut_rgb !== 24'h72C82F) begin
          mismatched++;
          $display("FAIL reset_first_pixel: pv=%b rgb=%h, want 1/72c82f", vga.pix_valid, dut_rgb);
        end
      end
    end
  endtask

  task test_border;
    int          bx [4] = '{79, 560, 300, 10};
    int          by [4] = '{5, 5, 480, 5};
    bit          bb [4] = '{0, 0, 0, 1};
    logic [23:0] be [4] = '{24'hA915F0, 24'h72C82F, 24'hA915F0, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1, bb[i], bx[i], by[i]);
      else drive(0, 0, 0, 0);
      @(negedge clk);
      if (i >= 4) begin
        compared++;
        if (vga.pix_valid !== 1'b1 || dut_rgb !== be[i-4]) begin
          mismatched++;
          $display("FAIL border_%0d: pv=%b rgb=%h, want 1/%h", i - 4, vga.pix_valid, dut_rgb, be[i-4]);
        end
      end
    end
  endtask

  task test_map_path;
    map_we = 1; map_addr = 8'd17; map_data = 4'd3;
    rom_mem[2822] = 4'd7;
    drive(0, 0, 0, 0);
    @(negedge clk);
    map_we = 0;
    drive(1, 0, 112, 34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0);
      if (i == 2) begin
        compared++;
        if (rom_addr !== 13'd2822) begin
          mismatched++;
          $display("FAIL map_rom_addr: got %0d, want 2822", rom_addr);
        end
      end
      if (i == 4) begin
        compared++;
        if (dut_rgb !== 24'hFCC656) begin
          mismatched++;
          $display("FAIL map_colour: got %h, want fcc656", dut_rgb);
        end
      end
    end
  endtask

  task test_palette;
    logic [23:0] want [2] = '{24'hFCC656, 24'h123456};
    for (int r = 0; r < 2; r++) begin
      drive(1, 0, 112, 34);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        drive(0, 0, 0, 0);
        pal_we = (r == 0 && i == 3);
        pal_addr = 4'd7;
        pal_data = 24'h123456;
        if (i == 4) begin
          compared++;
          if (dut_rgb !== want[r]) begin
            mismatched++;
            $display("FAIL palette_%0d: got %h, want %h", r, dut_rgb, want[r]);
          end
        end
      end
    end
  endtask

  task test_map_collision;
    rom_mem[4622] = 4'd9;
    map_we = 1; map_addr = 8'd17; map_data = 4'd5;
    drive(1, 0, 112, 34);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      map_we = 0;
      if (i == 0) drive(1, 0, 112, 34);
      else drive(0, 0, 0, 0);
      if (i == 2 || i == 3) begin
        compared++;
        if (rom_addr !== ((i == 2) ? 13'd2822 : 13'd4622)) begin
          mismatched++;
          $display("FAIL collide_rom_addr_%0d: got %0d, want %0d", i, rom_addr, (i == 2) ? 2822 : 4622);
        end
      end
      if (i == 4 || i == 5) begin
        compared++;
        if (dut_rgb !== ((i == 4) ? 24'h123456 : 24'hCB8C1A)) begin
          mismatched++;
          $display("FAIL collide_colour_%0d: got %h, want %h", i, dut_rgb, (i == 4) ? 24'h123456 : 24'hCB8C1A);
        end
      end
    end
  endtask

  task fill_map;
    for (int a = 0; a < 256; a++) begin
      map_we = 1; map_addr = 8'(a); map_data = 4'($urandom);
      @(negedge clk);
    end
    map_we = 0;
  endtask

  task test_stream;
    int y, g, xi, holes, zeros, nvalid;
    bit seen;
    y = $urandom_range(0, 479);
    g = $urandom_range(100, 380);
    xi = 0; holes = 0; zeros = 0; nvalid = 0; seen = 0;
    for (int c = 0; c < 489; c++) begin
      if (c >= 483) drive(0, 0, 0, 0);
      else if (c >= g && c < g + 3) drive(0, 0, 0, 0);
      else begin
        drive(1, 0, 80 + xi, y);
        xi++;
      end
      map_we = ($urandom_range(0, 7) == 0) && (c < 483);
      map_addr = 8'($urandom); map_data = 4'($urandom);
      pal_we = ($urandom_range(0, 15) == 0) && (c < 483);
      pal_addr = 4'($urandom); pal_data = 24'($urandom);
      @(negedge clk);
      compared++;
      if (vga.pix_valid !== exp_pv || dut_rgb !== exp_rgb) begin
        mismatched++;
        $display("FAIL stream c=%0d: pv=%b rgb=%h, want %b/%h", c, vga.pix_valid, dut_rgb, exp_pv, exp_rgb);
      end
      if (vga.pix_valid === 1'b1) begin
        if (seen) holes += zeros;
        zeros = 0; seen = 1; nvalid++;
      end else if (seen) zeros++;
    end
    map_we = 0; pal_we = 0;
    compared++;
    if (holes != 3 || nvalid != 480) begin
      mismatched++;
      $display("FAIL stream_hole: hole=%0d valid=%0d, want 3/480", holes, nvalid);
    end
  endtask

  task test_random;
    int xs [6] = '{79, 80, 109, 110, 559, 560};
    int ys [4] = '{0, 29, 479, 480};
    int x, y;
    for (int c = 0; c < 400; c++) begin
      x = ($urandom_range(0, 3) == 0) ? xs[$urandom_range(0, 5)] : $urandom_range(0, 700);
      y = ($urandom_range(0, 3) == 0) ? ys[$urandom_range(0, 3)] : $urandom_range(0, 520);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, x, y);
      map_we = ($urandom_range(0, 5) == 0);
      map_addr = 8'($urandom); map_data = 4'($urandom);
      pal_we = ($urandom_range(0, 9) == 0);
      pal_addr = 4'($urandom); pal_data = 24'($urandom);
      @(negedge clk);
      compared++;
      if (vga.pix_valid !== exp_pv || dut_rgb !== exp_rgb) begin
        mismatched++;
        $display("FAIL random c=%0d: pv=%b rgb=%h, want %b/%h", c, vga.pix_valid, dut_rgb, exp_pv, exp_rgb);
      end
    end
    map_we = 0; pal_we = 0;
  endtask

  initial begin
    map_we = 0; map_addr = '0; map_data = '0;
    pal_we = 0; pal_addr = '0; pal_data = '0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 8192; i++) rom_mem[i] = 4'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_border;
    test_map_path;
    test_palette;
    test_map_collision;
    fill_map;
    test_stream;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
